// File: rtl/pwm_hbridge.sv
// pwm_hbridge: H-bridge PWM generator with a double-buffered 8-bit duty register
// and programmable dead time between complementary gate drives.
// Ports:
//   clk_i, reset_i        - clock, synchronous active-high reset
//   pwmcntce_i            - period counter clock enable
//   motorenaint_i         - motor enable
//   invertpwm_i           - invert raw compare result (latched while disabled)
//   invphase_i            - direction / switching-leg select (latched while disabled)
//   dutyld_i, wrtdata_i   - duty register load strobe and data
//   hs_a_o, ls_a_o        - leg A high/low-side gate drives (registered)
//   hs_b_o, ls_b_o        - leg B high/low-side gate drives (registered)
//   pwmwrap_o             - one-clock pulse at the start of each PWM period (registered)
//   dutyrddata_o          - pending duty value
module pwm_hbridge #(
  parameter int unsigned DEADTIME = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       pwmcntce_i,
  input  logic       motorenaint_i,
  input  logic       invertpwm_i,
  input  logic       invphase_i,
  input  logic       dutyld_i,
  input  logic [7:0] wrtdata_i,
  output logic       hs_a_o,
  output logic       ls_a_o,
  output logic       hs_b_o,
  output logic       ls_b_o,
  output logic       pwmwrap_o,
  output logic [7:0] dutyrddata_o
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(254);
  localparam logic [DT_W-1:0]  DT_LOAD  = DT_W'(DEADTIME - 1);

  localparam logic [2:0] ST_OFF  = 3'd0;
  localparam logic [2:0] ST_ARM  = 3'd1;
  localparam logic [2:0] ST_HIGH = 3'd2;
  localparam logic [2:0] ST_LOW  = 3'd3;
  localparam logic [2:0] ST_DEAD = 3'd4;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       duty_pend_q, duty_pend_d;
  logic [7:0]       duty_act_q, duty_act_d;
  logic             inv_l_q, inv_l_d;
  logic             iph_l_q, iph_l_d;
  logic [2:0]       state_q, state_d;
  logic [DT_W-1:0]  dcnt_q, dcnt_d;
  logic             tgt_hi_q, tgt_hi_d;
  logic             hs_a_q, hs_a_d, ls_a_q, ls_a_d;
  logic             hs_b_q, hs_b_d, ls_b_q, ls_b_d;
  logic             wrap_q;

  logic wrap_c;
  logic raw_c;
  logic sw_hs_c, sw_ls_c, st_ls_c;

  assign wrap_c = motorenaint_i & pwmcntce_i & (cnt_q == CNT_LAST);
  assign raw_c  = (cnt_q < duty_act_q) ^ inv_l_q;

  // Period counter, duty double buffer and config latches.
  always_comb begin
    cnt_d       = cnt_q;
    duty_pend_d = duty_pend_q;
    duty_act_d  = duty_act_q;
    inv_l_d     = inv_l_q;
    iph_l_d     = iph_l_q;
    if (!motorenaint_i) begin
      cnt_d      = '0;
      duty_act_d = duty_pend_q;
      inv_l_d    = invertpwm_i;
      iph_l_d    = invphase_i;
    end else if (pwmcntce_i) begin
      cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
    end
    // Copy happens from the old pending value, so a load on the wrap clock waits a period.
    if (wrap_c) duty_act_d = duty_pend_q;
    if (dutyld_i) duty_pend_d = wrtdata_i;
  end

  // Gate FSM for the switching leg.
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    tgt_hi_d = tgt_hi_q;
    if (!motorenaint_i) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_ARM;
          dcnt_d  = DT_LOAD;
        end
        ST_ARM: begin
          if (dcnt_q == '0) state_d = raw_c ? ST_HIGH : ST_LOW;
          else              dcnt_d  = dcnt_q - DT_W'(1);
        end
        ST_HIGH: begin
          if (!raw_c) begin
            state_d  = ST_DEAD;
            tgt_hi_d = 1'b0;
            dcnt_d   = DT_LOAD;
          end
        end
        ST_LOW: begin
          if (raw_c) begin
            state_d  = ST_DEAD;
            tgt_hi_d = 1'b1;
            dcnt_d   = DT_LOAD;
          end
        end
        ST_DEAD: begin
          // A raw change during dead time retargets and restarts, swallowing short pulses.
          if (raw_c != tgt_hi_q) begin
            tgt_hi_d = raw_c;
            dcnt_d   = DT_LOAD;
          end else if (dcnt_q == '0) begin
            state_d = tgt_hi_q ? ST_HIGH : ST_LOW;
          end else begin
            dcnt_d = dcnt_q - DT_W'(1);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Gate decode from the next state so outputs land one clock after their cause.
  always_comb begin
    sw_hs_c = (state_d == ST_HIGH);
    sw_ls_c = (state_d == ST_LOW);
    st_ls_c = (state_d == ST_HIGH) || (state_d == ST_LOW) || (state_d == ST_DEAD);
    hs_a_d  = ~iph_l_q & sw_hs_c;
    ls_a_d  = iph_l_q ? st_ls_c : sw_ls_c;
    hs_b_d  = iph_l_q & sw_hs_c;
    ls_b_d  = iph_l_q ? sw_ls_c : st_ls_c;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      duty_pend_q <= '0;
      duty_act_q  <= '0;
      inv_l_q     <= 1'b0;
      iph_l_q     <= 1'b0;
      state_q     <= ST_OFF;
      dcnt_q      <= '0;
      tgt_hi_q    <= 1'b0;
      hs_a_q      <= 1'b0;
      ls_a_q      <= 1'b0;
      hs_b_q      <= 1'b0;
      ls_b_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      duty_pend_q <= duty_pend_d;
      duty_act_q  <= duty_act_d;
      inv_l_q     <= inv_l_d;
      iph_l_q     <= iph_l_d;
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      tgt_hi_q    <= tgt_hi_d;
      hs_a_q      <= hs_a_d;
      ls_a_q      <= ls_a_d;
      hs_b_q      <= hs_b_d;
      ls_b_q      <= ls_b_d;
      wrap_q      <= wrap_c;
    end
  end

  assign hs_a_o       = hs_a_q;
  assign ls_a_o       = ls_a_q;
  assign hs_b_o       = hs_b_q;
  assign ls_b_o       = ls_b_q;
  assign pwmwrap_o    = wrap_q;
  assign dutyrddata_o = duty_pend_q;

endmodule

// File: tb/tb_pwm_hbridge.sv
// tb_pwm_hbridge: scoreboard bench for pwm_hbridge with a window-based gate model
// (a gate turns on once raw has been steady for DEADTIME+1 samples) and
// per-period gate-time statistics for the steady-state scenarios.
module tb_pwm_hbridge;

  localparam int DT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pwmcntce = 1'b0;
  logic       motorenaint = 1'b0;
  logic       invertpwm = 1'b0;
  logic       invphase = 1'b0;
  logic       dutyld = 1'b0;
  logic [7:0] wrtdata = 8'd0;
  logic       hs_a, ls_a, hs_b, ls_b, pwmwrap;
  logic [7:0] dutyrd;

  pwm_hbridge #(.DEADTIME(DT)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .pwmcntce_i   (pwmcntce),
    .motorenaint_i(motorenaint),
    .invertpwm_i  (invertpwm),
    .invphase_i   (invphase),
    .dutyld_i     (dutyld),
    .wrtdata_i    (wrtdata),
    .hs_a_o       (hs_a),
    .ls_a_o       (ls_a),
    .hs_b_o       (hs_b),
    .ls_b_o       (ls_b),
    .pwmwrap_o    (pwmwrap),
    .dutyrddata_o (dutyrd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hs_a;
    logic       ls_a;
    logic       hs_b;
    logic       ls_b;
    logic       wrap;
    logic [7:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Per-period statistics control (written by stimulus, read by monitor).
  bit stats_en = 1'b0;
  int exp_st[4];

  // Reference model state.
  int m_cnt = 0, m_act = 0, m_pend = 0;
  bit m_inv = 1'b0, m_iph = 1'b0;
  int m_k = -1;
  bit m_rv = 1'b0;
  int m_rl = 0;
  bit m_hs_a = 1'b0;

  bit cur_ce = 1'b0, cur_en = 1'b0, cur_inv = 1'b0, cur_iph = 1'b0;

  task automatic step(input bit r, input bit c, input bit e, input bit i, input bit p,
                      input bit l, input logic [7:0] d);
    bit   raw, on, hs_sw, ls_sw, wrap;
    exp_t x;
    @(negedge clk);
    reset = r; pwmcntce = c; motorenaint = e; invertpwm = i; invphase = p;
    dutyld = l; wrtdata = d;
    raw = bit'(m_cnt < m_act) ^ m_inv;
    if (r || !e)       m_k = -1;
    else if (m_k < 0)  m_k = 0;
    else if (m_k < 1000000) m_k++;
    on = (m_k >= DT);
    if (m_k == DT) begin
      m_rv = raw; m_rl = DT + 1;
    end else if (m_k > DT) begin
      if (raw == m_rv) begin
        if (m_rl < 1000) m_rl++;
      end else begin
        m_rv = raw; m_rl = 1;
      end
    end
    hs_sw = on && m_rv && (m_rl >= DT + 1);
    ls_sw = on && !m_rv && (m_rl >= DT + 1);
    x.hs_a = !m_iph && hs_sw;
    x.ls_a = m_iph ? on : ls_sw;
    x.hs_b = m_iph && hs_sw;
    x.ls_b = m_iph ? ls_sw : on;
    wrap = !r && e && c && (m_cnt == 254);
    x.wrap = wrap;
    if (r) begin
      m_cnt = 0; m_act = 0; m_pend = 0; m_inv = 1'b0; m_iph = 1'b0;
    end else begin
      if (!e || wrap) m_act = m_pend;
      if (!e)         m_cnt = 0;
      else if (c)     m_cnt = (m_cnt + 1) % 255;
      if (!e) begin m_inv = i; m_iph = p; end
      if (l)  m_pend = int'(d);
    end
    x.rd = 8'(m_pend);
    m_hs_a = x.hs_a;
    exp_q.push_back(x);
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) step(1'b0, cur_ce, cur_en, cur_inv, cur_iph, 1'b0, 8'd0);
  endtask

  task automatic load(input logic [7:0] d);
    step(1'b0, cur_ce, cur_en, cur_inv, cur_iph, 1'b1, d);
  endtask

  task automatic steady(input bit i, input bit p, input logic [7:0] d,
                        input int e0, input int e1, input int e2, input int e3);
    stats_en = 1'b0;
    cur_en = 1'b0; cur_ce = 1'b1; cur_inv = i; cur_iph = p;
    run(2);
    load(d);
    run(2);
    exp_st[0] = e0; exp_st[1] = e1; exp_st[2] = e2; exp_st[3] = e3;
    stats_en = 1'b1;
    cur_en = 1'b1;
    run(800);
    stats_en = 1'b0;
  endtask

  // Monitor: pops one expectation per clock, checks gate exclusivity and period stats.
  initial begin : monitor
    exp_t        e;
    logic [12:0] act;
    int          st[4];
    bit          seen;
    logic [3:0]  g;
    seen = 1'b0;
    for (int j = 0; j < 4; j++) st[j] = 0;
    forever begin
      @(posedge clk);
      #1;
      act = {hs_a, ls_a, hs_b, ls_b, pwmwrap, dutyrd};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (act !== 13'(e)) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t got hs_a/ls_a/hs_b/ls_b/wrap/rd=%b expected %b",
                   $time, act, 13'(e));
        end
      end
      n_checks++;
      if ((hs_a === 1'b1 && ls_a === 1'b1) || (hs_b === 1'b1 && ls_b === 1'b1)) begin
        n_fail++;
        $display("FAIL shoot_through t=%0t got a=%b%b b=%b%b expected no leg with both on",
                 $time, hs_a, ls_a, hs_b, ls_b);
      end
      g = {hs_a, ls_a, hs_b, ls_b};
      if (!stats_en) begin
        seen = 1'b0;
        for (int j = 0; j < 4; j++) st[j] = 0;
      end else begin
        if (pwmwrap === 1'b1) begin
          if (seen) begin
            for (int j = 0; j < 4; j++) begin
              if (exp_st[j] >= 0) begin
                n_checks++;
                if (st[j] != exp_st[j]) begin
                  n_fail++;
                  $display("FAIL period_gate%0d t=%0t got %0d clocks high expected %0d",
                           j, $time, st[j], exp_st[j]);
                end
              end
            end
          end
          seen = 1'b1;
          for (int j = 0; j < 4; j++) st[j] = 0;
        end
        for (int j = 0; j < 4; j++) if (g[3-j] === 1'b1) st[j]++;
      end
    end
  end

  initial begin : stimulus
    // Reset with random inputs.
    for (int j = 0; j < 3; j++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom));
    run(2);

    // Steady PWM, direction 0, duty 64.
    steady(1'b0, 1'b0, 8'd64, 60, 187, 0, 255);
    // Direction and inversion.
    steady(1'b1, 1'b1, 8'd64, 0, 255, 187, 60);
    // Duty boundaries.
    steady(1'b0, 1'b0, 8'd0, 0, 255, 0, 255);
    steady(1'b0, 1'b0, 8'd255, 255, 0, 0, 255);
    steady(1'b0, 1'b0, 8'd2, 0, -1, 0, 255);

    // Double buffer: mid-period write, then write on the wrap clock.
    cur_en = 1'b0; cur_inv = 1'b0; cur_iph = 1'b0; cur_ce = 1'b1;
    run(2);
    load(8'd64);
    cur_en = 1'b1;
    run(20);
    for (int j = 0; j < 600 && m_cnt != 100; j++) run(1);
    load(8'd200);
    for (int j = 0; j < 600 && m_cnt != 254; j++) run(1);
    load(8'd30);
    run(600);

    // Drop enable while hs_a is on, then re-enable.
    load(8'd200);
    run(300);
    for (int j = 0; j < 600 && !m_hs_a; j++) run(1);
    cur_en = 1'b0;
    run(5);
    cur_en = 1'b1;
    run(300);
    // Reset mid-period while enabled.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    run(300);

    // Randomized traffic.
    cur_en = 1'b1;
    for (int j = 0; j < 20000; j++) begin
      if ($urandom_range(0, 299) == 0) cur_en = !cur_en;
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 9) < 8, cur_en,
           1'($urandom), 1'($urandom), $urandom_range(0, 39) == 0, 8'($urandom));
    end
    cur_en = 1'b0;
    run(3);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
